// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives pll_rst, qualifies pll_locked, retries on timeout, releases sys_rst_n after stable lock.
// Define PLL_SUP_LOSS_CNT_EN to implement the saturating lock_loss_cnt register; otherwise the port reads 8'd0.
module pll_lock_supervisor #(
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);
  // state     | meaning
  // RESET_PLL | pll_rst held high for RST_HOLD_CYCLES
  // WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT
  // STABLE    | locked_s must stay high for LOCK_STABLE_CYCLES
  // RUN       | downstream released, watching for lock loss
  // FAIL      | retries exhausted, parked until force_relock
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [16:0] RST_LAST     = 17'(RST_HOLD_CYCLES - 1);
  localparam logic [16:0] TIMEOUT_LAST = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] STABLE_LAST  = 17'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [1:0]  sync_q, sync_d;
  logic        pll_rst_q, pll_rst_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        locked_s;

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    sync_d  = {sync_q[0], pll_locked};
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = RESET_PLL;
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        // lock loss wins over a simultaneous force_relock
        if (!locked_s || force_relock) state_d = RESET_PLL;
      end
      FAIL: begin
        if (force_relock) begin
          retry_d = '0;
          state_d = RESET_PLL;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    cnt_d       = (state_d != state_q) ? '0 : cnt_q + 17'd1;
    pll_rst_d   = (state_d == RESET_PLL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == RUN && !locked_s && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus predicts output-change events (cycle, value) from timing rules;
// a monitor pops them whenever the DUT's output tuple changes.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;
  localparam int RH = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;

  localparam int S_RST  = 0;
  localparam int S_IDLE = 1;
  localparam int S_RUN  = 2;
  localparam int S_FAIL = 3;

  localparam logic [15:0] RST_TUP = 16'h8000;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES(RH),
    .LOCK_TIMEOUT(LT),
    .LOCK_STABLE_CYCLES(LS),
    .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          exp_retry = 0;
  int          exp_loss = 0;
  logic [15:0] exp_last = RST_TUP;
  int          w_start = 0;
  int          run_start = 0;
  int          fail_at = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  // Queue the expected output tuple for a state entered at edge 'at'; no entry if outputs do not change.
  task automatic push(input int at, input int st);
    logic [15:0] v;
    ev_t         e;
    v = {st == S_RST, st == S_RUN, st == S_RUN, st == S_FAIL, exp_retry[3:0], exp_loss[7:0]};
    if (v != exp_last) begin
      e.cyc = at;
      e.val = v;
      exp_q.push_back(e);
      exp_last = v;
    end
  endtask

  task automatic count_loss();
`ifdef PLL_SUP_LOSS_CNT_EN
    if (exp_loss < 255) exp_loss++;
`endif
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    w_start = cyc + RH;
    push(w_start, S_IDLE);
  endtask

  task automatic assert_reset();
    int a;
    a = cyc;
    exp_retry = 0;
    exp_loss  = 0;
    push(a + 1, S_RST);
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    wait_until(a + 3);
  endtask

  // Raise lock at negedge after edge t; ignored force_relock pulses in WAIT/RESET and STABLE; optional STABLE glitch.
  task automatic acquire(input int t_req, input bit glitch);
    int t, s, td, tr, run_at;
    t  = (t_req < cyc) ? cyc : t_req;
    s  = (w_start + 1 > t + 3) ? w_start + 1 : t + 3;
    td = s + 3 + int'($urandom_range(0, 2));
    tr = td + int'($urandom_range(1, 4));
    run_at = glitch ? tr + 3 + LS : s + LS;
    exp_retry = 0;
    push(run_at, S_RUN);
    wait_until(t);
    pll_locked   = 1'b1;
    force_relock = 1'b1;
    wait_until(t + 1);
    force_relock = 1'b0;
    wait_until(s + 1);
    force_relock = 1'b1;
    wait_until(s + 2);
    force_relock = 1'b0;
    if (glitch) begin
      wait_until(td);
      pll_locked = 1'b0;
      wait_until(tr);
      pll_locked = 1'b1;
    end
    wait_until(run_at);
    run_start = run_at;
  endtask

  task automatic time_out();
    int t_end;
    t_end = w_start + LT;
    if (exp_retry == MR) begin
      push(t_end, S_FAIL);
      fail_at = t_end;
    end else begin
      exp_retry++;
      push(t_end, S_RST);
      w_start = t_end + RH;
      push(w_start, S_IDLE);
    end
  endtask

  task automatic fail_recover();
    int f;
    wait_until(fail_at + int'($urandom_range(1, 5)));
    f = cyc;
    exp_retry = 0;
    push(f + 1, S_RST);
    w_start = f + 1 + RH;
    push(w_start, S_IDLE);
    force_relock = 1'b1;
    wait_until(f + 1);
    force_relock = 1'b0;
  endtask

  // Lock drops for g cycles in RUN; optionally force_relock arrives on the same edge the loss is seen.
  task automatic run_loss(input bit with_force);
    int t, g;
    t = cyc + int'($urandom_range(1, 6));
    g = int'($urandom_range(1, 3));
    count_loss();
    push(t + 3, S_RST);
    push(t + 3 + RH, S_IDLE);
    push(t + 3 + RH + 1 + LS, S_RUN);
    for (int k = 0; k <= 3; k++) begin
      wait_until(t + k);
      if (k == 0) pll_locked = 1'b0;
      if (k == g) pll_locked = 1'b1;
      force_relock = with_force && (k == 2);
    end
    run_start = t + 3 + RH + 1 + LS;
    wait_until(run_start);
  endtask

  task automatic force_only();
    int t;
    t = cyc + int'($urandom_range(1, 6));
    push(t + 1, S_RST);
    push(t + 1 + RH, S_IDLE);
    push(t + 1 + RH + 1 + LS, S_RUN);
    wait_until(t);
    force_relock = 1'b1;
    wait_until(t + 1);
    force_relock = 1'b0;
    run_start = t + 1 + RH + 1 + LS;
    wait_until(run_start);
  endtask

  task automatic loss_hold_reset();
    int t;
    t = cyc + int'($urandom_range(1, 6));
    count_loss();
    push(t + 3, S_RST);
    push(t + 3 + RH, S_IDLE);
    wait_until(t);
    pll_locked = 1'b0;
    wait_until(t + 3 + RH + int'($urandom_range(1, 10)));
    assert_reset();
  endtask

  logic [15:0] mon_last;
  logic [15:0] mon_cur;
  ev_t         mon_ev;
  bit          mon_init = 1'b0;

  always @(posedge refclk) begin
    #1;
    mon_cur = {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt};
    if (!mon_init) begin
      checks++;
      if (mon_cur !== RST_TUP) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, mon_cur, RST_TUP);
      end
      mon_last = mon_cur;
      mon_init = 1'b1;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event exp_cyc=%0d exp=%h now=%0d got=%h", exp_q[0].cyc, exp_q[0].val, cyc, mon_cur);
        void'(exp_q.pop_front());
      end
      if (mon_cur !== mon_last) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          mon_ev = exp_q.pop_front();
          if (mon_ev.val !== mon_cur) begin
            errors++;
            $display("FAIL event_value cyc=%0d got=%h exp=%h", cyc, mon_cur, mon_ev.val);
          end
        end else begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%h prev=%h", cyc, mon_cur, mon_last);
        end
        mon_last = mon_cur;
      end
    end
  end

  initial begin
    #(20 * 40000);
    errors++;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    wait_until(3);

    release_reset();
    acquire(w_start + 5, 1'b0);
    force_only();
    run_loss(1'b0);
    run_loss(1'b1);

    assert_reset();
    release_reset();
    repeat (MR + 1) time_out();
    fail_recover();
    if ($urandom_range(0, 1) == 1) time_out();
    acquire(w_start + int'($urandom_range(0, 16)), 1'b1);

    repeat (12) begin
      case ($urandom_range(0, 2))
        0:       run_loss(1'b0);
        1:       run_loss(1'b1);
        default: force_only();
      endcase
    end

    repeat (260) run_loss($urandom_range(0, 1) == 1);

    loss_hold_reset();
    release_reset();
    acquire(w_start + int'($urandom_range(0, 16)), $urandom_range(0, 1) == 1);
    run_loss(1'b0);

    wait_until(cyc + 30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events left=%0d next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
